// File: rtl/ysyx_22040237_idu_stage.sv
// Instruction decode stage: decodes a small RV64I subset, reads the register file
// in the same cycle and presents registered operands behind a valid/ready skid-free stage.
module ysyx_22040237_idu_stage #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            rs1_r_en,
  output logic            rs2_r_en,
  output logic [4:0]      rs1_r_addr,
  output logic [4:0]      rs2_r_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [7:0]      out_opcode,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] op1_jump,
  output logic [XLEN-1:0] op2_jump,
  output logic [XLEN-1:0] store_data,
  output logic            jump_flag,
  output logic            is_store,
  output logic            inst_ebreak,
  output logic            invalid_inst,
  output logic            rd_w_en,
  output logic [4:0]      rd_w_addr,
  output logic [CNTW-1:0] invalid_cnt
);

  logic [6:0] opc;
  logic [2:0] funct3;
  logic is_addi, is_ebreak, is_auipc, is_lui, is_jal, is_jalr, is_sd, writes_rd, is_bad;

  assign opc       = in_inst[6:0];
  assign funct3    = in_inst[14:12];
  assign is_addi   = (opc == 7'b0010011) && (funct3 == 3'b000);
  assign is_ebreak = (in_inst == 32'h0010_0073);
  assign is_auipc  = (opc == 7'b0010111);
  assign is_lui    = (opc == 7'b0110111);
  assign is_jal    = (opc == 7'b1101111);
  assign is_jalr   = (opc == 7'b1100111) && (funct3 == 3'b000);
  assign is_sd     = (opc == 7'b0100011) && (funct3 == 3'b011);
  assign writes_rd = is_addi | is_auipc | is_lui | is_jal | is_jalr;
  assign is_bad    = ~(writes_rd | is_sd | is_ebreak);

  // Signed immediates; the width cast sign-extends to XLEN
  logic signed [11:0] imm_i12, imm_s12;
  logic signed [31:0] imm_u32;
  logic signed [20:0] imm_j21;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, imm_j, four;

  assign imm_i12 = in_inst[31:20];
  assign imm_s12 = {in_inst[31:25], in_inst[11:7]};
  assign imm_u32 = {in_inst[31:12], 12'b0};
  assign imm_j21 = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign imm_i   = XLEN'(imm_i12);
  assign imm_s   = XLEN'(imm_s12);
  assign imm_u   = XLEN'(imm_u32);
  assign imm_j   = XLEN'(imm_j21);
  assign four    = XLEN'(3'd4);

  assign rs1_r_en   = in_valid & (is_addi | is_jalr | is_sd);
  assign rs2_r_en   = in_valid & is_sd;
  assign rs1_r_addr = rs1_r_en ? in_inst[19:15] : 5'd0;
  assign rs2_r_addr = rs2_r_en ? in_inst[24:20] : 5'd0;

  assign in_ready = ~rst & ~flush & (~out_valid | out_ready);

  logic [XLEN-1:0] d_op1, d_op2, d_op1_jump, d_op2_jump, d_store_data;
  logic [7:0]      d_opcode;

  // Operand selection per instruction class; anything unused stays zero
  always_comb begin
    d_op1        = '0;
    d_op2        = '0;
    d_op1_jump   = '0;
    d_op2_jump   = '0;
    d_store_data = '0;
    d_opcode     = 8'h00;
    if (is_addi) begin
      d_op1 = rs1_data;
      d_op2 = imm_i;
    end else if (is_lui) begin
      d_op2 = imm_u;
    end else if (is_auipc) begin
      d_op1 = in_pc;
      d_op2 = imm_u;
    end else if (is_jal) begin
      d_op1      = in_pc;
      d_op2      = four;
      d_op1_jump = in_pc;
      d_op2_jump = imm_j;
    end else if (is_jalr) begin
      d_op1      = in_pc;
      d_op2      = four;
      d_op1_jump = rs1_data;
      d_op2_jump = imm_i;
    end else if (is_sd) begin
      d_op1        = rs1_data;
      d_op2        = imm_s;
      d_store_data = rs2_data;
    end
    if (writes_rd) d_opcode = 8'h01;
    else if (is_sd) d_opcode = 8'h02;
  end

  logic capture;
  assign capture = in_valid & in_ready;

  // Output register: flush beats capture, capture beats drain
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_opcode   <= 8'h00;
      op1          <= '0;
      op2          <= '0;
      op1_jump     <= '0;
      op2_jump     <= '0;
      store_data   <= '0;
      jump_flag    <= 1'b0;
      is_store     <= 1'b0;
      inst_ebreak  <= 1'b0;
      invalid_inst <= 1'b0;
      rd_w_en      <= 1'b0;
      rd_w_addr    <= 5'd0;
      invalid_cnt  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_opcode   <= d_opcode;
      op1          <= d_op1;
      op2          <= d_op2;
      op1_jump     <= d_op1_jump;
      op2_jump     <= d_op2_jump;
      store_data   <= d_store_data;
      jump_flag    <= is_jal | is_jalr;
      is_store     <= is_sd;
      inst_ebreak  <= is_ebreak;
      invalid_inst <= is_bad;
      rd_w_en      <= writes_rd;
      rd_w_addr    <= writes_rd ? in_inst[11:7] : 5'd0;
      if (is_bad && (invalid_cnt != {CNTW{1'b1}}))
        invalid_cnt <= invalid_cnt + CNTW'(1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_idu_stage.sv
// Scoreboard bench for the decode stage: a 64-bit/16-bit-counter instance and a
// 32-bit/2-bit-counter instance run side by side on the same stimulus.
module tb_ysyx_22040237_idu_stage;

  typedef struct packed {
    logic [63:0] pc;
    logic [7:0]  opc;
    logic [63:0] op1, op2, op1j, op2j, sdata;
    logic        jump, store, ebreak, invalid, rdwen;
    logic [4:0]  rd;
    logic [15:0] cnt;
    logic [31:0] op1_lo, op2_lo;
    logic [1:0]  cnt2;
  } exp_t;

  localparam int K_INV = 0, K_ADDI = 1, K_EBREAK = 2, K_AUIPC = 3, K_LUI = 4,
                 K_JAL = 5, K_JALR = 6, K_SD = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, flush;
  logic [31:0] in_inst;
  logic [63:0] in_pc, rs1_data, rs2_data;

  logic        in_ready, rs1_r_en, rs2_r_en, out_valid, jump_flag, is_store, inst_ebreak;
  logic        invalid_inst, rd_w_en;
  logic [4:0]  rs1_r_addr, rs2_r_addr, rd_w_addr;
  logic [63:0] out_pc, op1, op2, op1_jump, op2_jump, store_data;
  logic [7:0]  out_opcode;
  logic [15:0] invalid_cnt;

  logic        b_in_ready, b_rs1_r_en, b_rs2_r_en, b_out_valid, b_jump_flag, b_is_store;
  logic        b_inst_ebreak, b_invalid_inst, b_rd_w_en;
  logic [4:0]  b_rs1_r_addr, b_rs2_r_addr, b_rd_w_addr;
  logic [31:0] b_out_pc, b_op1, b_op2, b_op1_jump, b_op2_jump, b_store_data;
  logic [7:0]  b_out_opcode;
  logic [1:0]  b_cnt;

  ysyx_22040237_idu_stage #(.XLEN(64), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .rs1_r_en(rs1_r_en), .rs2_r_en(rs2_r_en), .rs1_r_addr(rs1_r_addr),
    .rs2_r_addr(rs2_r_addr), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode),
    .op1(op1), .op2(op2), .op1_jump(op1_jump), .op2_jump(op2_jump), .store_data(store_data),
    .jump_flag(jump_flag), .is_store(is_store), .inst_ebreak(inst_ebreak),
    .invalid_inst(invalid_inst), .rd_w_en(rd_w_en), .rd_w_addr(rd_w_addr),
    .invalid_cnt(invalid_cnt)
  );

  ysyx_22040237_idu_stage #(.XLEN(32), .CNTW(2)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_pc(in_pc[31:0]),
    .in_inst(in_inst), .rs1_r_en(b_rs1_r_en), .rs2_r_en(b_rs2_r_en),
    .rs1_r_addr(b_rs1_r_addr), .rs2_r_addr(b_rs2_r_addr), .rs1_data(rs1_data[31:0]),
    .rs2_data(rs2_data[31:0]), .flush(flush), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_pc(b_out_pc), .out_opcode(b_out_opcode), .op1(b_op1),
    .op2(b_op2), .op1_jump(b_op1_jump), .op2_jump(b_op2_jump), .store_data(b_store_data),
    .jump_flag(b_jump_flag), .is_store(b_is_store), .inst_ebreak(b_inst_ebreak),
    .invalid_inst(b_invalid_inst), .rd_w_en(b_rd_w_en), .rd_w_addr(b_rd_w_addr),
    .invalid_cnt(b_cnt)
  );

  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];
  logic m_valid = 1'b0;
  int   m_cnt = 0;
  int   m_cnt2 = 0;

  function automatic int kind_of(input logic [31:0] i);
    casez (i)
      32'h0010_0073:                          return K_EBREAK;
      32'b?????????_????????_000_?????_0010011: return K_ADDI;
      32'b?????????_?????????_???????_0010111:  return K_AUIPC;
      32'b?????????_?????????_???????_0110111:  return K_LUI;
      32'b?????????_?????????_???????_1101111:  return K_JAL;
      32'b?????????_????????_000_?????_1100111: return K_JALR;
      32'b?????????_????????_011_?????_0100011: return K_SD;
      default:                                return K_INV;
    endcase
  endfunction

  // Architectural meaning of each instruction, written with signed arithmetic
  function automatic exp_t model(input logic [31:0] i, input logic [63:0] pc, d1, d2);
    exp_t e;
    longint si;
    logic signed [20:0] jv;
    logic [63:0] ii, is, iu, ij;
    e = '0;
    e.pc = pc;
    si = longint'($signed(i));
    ii = si >>> 20;
    is = ((si >>> 25) <<< 5) | longint'(i[11:7]);
    iu = (si >>> 12) <<< 12;
    jv = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    ij = longint'(jv);
    case (kind_of(i))
      K_ADDI:   begin e.op1 = d1; e.op2 = ii; e.opc = 8'h01; e.rdwen = 1'b1; end
      K_LUI:    begin e.op2 = iu; e.opc = 8'h01; e.rdwen = 1'b1; end
      K_AUIPC:  begin e.op1 = pc; e.op2 = iu; e.opc = 8'h01; e.rdwen = 1'b1; end
      K_JAL:    begin e.op1 = pc; e.op2 = 64'd4; e.op1j = pc; e.op2j = ij;
                      e.opc = 8'h01; e.rdwen = 1'b1; e.jump = 1'b1; end
      K_JALR:   begin e.op1 = pc; e.op2 = 64'd4; e.op1j = d1; e.op2j = ii;
                      e.opc = 8'h01; e.rdwen = 1'b1; e.jump = 1'b1; end
      K_SD:     begin e.op1 = d1; e.op2 = is; e.sdata = d2; e.opc = 8'h02; e.store = 1'b1; end
      K_EBREAK: e.ebreak = 1'b1;
      default:  e.invalid = 1'b1;
    endcase
    if (e.rdwen) e.rd = i[11:7];
    e.op1_lo = e.op1[31:0];
    e.op2_lo = e.op2[31:0];
    return e;
  endfunction

  function automatic exp_t dut_view();
    exp_t e;
    e = '{pc: out_pc, opc: out_opcode, op1: op1, op2: op2, op1j: op1_jump, op2j: op2_jump,
          sdata: store_data, jump: jump_flag, store: is_store, ebreak: inst_ebreak,
          invalid: invalid_inst, rdwen: rd_w_en, rd: rd_w_addr, cnt: invalid_cnt,
          op1_lo: b_op1, op2_lo: b_op2, cnt2: b_cnt};
    return e;
  endfunction

  task automatic cmp(input string name, input exp_t got, input exp_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cmp_v(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: return {r[31:15], 3'b000, r[11:7], 7'b0010011};
      1: return {r[31:7], 7'b0010111};
      2: return {r[31:7], 7'b0110111};
      3: return {r[31:7], 7'b1101111};
      4: return {r[31:15], 3'b000, r[11:7], 7'b1100111};
      5: return {r[31:15], 3'b011, r[11:7], 7'b0100011};
      6: return 32'h0010_0073;
      7: return 32'h0000_0000;
      default: return r;
    endcase
  endfunction

  // One cycle of stimulus; the bench's own handshake model decides what gets accepted
  task automatic step(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                      input logic [63:0] d1, d2, input logic ordy, fl, r);
    logic er, e1, e2;
    int k;
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; in_inst = inst; in_pc = pc;
    rs1_data = d1; rs2_data = d2; out_ready = ordy; flush = fl;
    #1;
    er = !r && !fl && (!m_valid || ordy);
    cmp_v("handshake", {60'd0, out_valid, in_ready, b_out_valid, b_in_ready},
          {60'd0, m_valid, er, m_valid, er});
    k  = kind_of(inst);
    e1 = v && (k == K_ADDI || k == K_JALR || k == K_SD);
    e2 = v && (k == K_SD);
    cmp_v("regread", {40'd0, rs1_r_en, rs1_r_addr, rs2_r_en, rs2_r_addr,
                      b_rs1_r_en, b_rs1_r_addr, b_rs2_r_en, b_rs2_r_addr},
          {40'd0, e1, e1 ? inst[19:15] : 5'd0, e2, e2 ? inst[24:20] : 5'd0,
                  e1, e1 ? inst[19:15] : 5'd0, e2, e2 ? inst[24:20] : 5'd0});
    if (r) begin
      q.delete();
      m_valid = 1'b0; m_cnt = 0; m_cnt2 = 0;
    end else if (fl) begin
      m_valid = 1'b0;
    end else if (v && er) begin
      e = model(inst, pc, d1, d2);
      if (e.invalid) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      e.cnt  = 16'(m_cnt);
      e.cnt2 = 2'(m_cnt2);
      q.push_back(e);
      m_valid = 1'b1;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
  endtask

  // Monitor: hold check while stalled, pop-and-compare on transfer, discard on flush
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid === 1'b1) begin
        if (q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_output got out_valid=1 exp out_valid=0");
        end else if (flush) begin
          void'(q.pop_front());
        end else if (out_ready) begin
          cmp("transfer", dut_view(), q.pop_front());
        end else begin
          cmp("hold", dut_view(), q[0]);
        end
      end
    end
  end

  initial begin
    logic [63:0] pc;
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0;
    rs1_data = '0; rs2_data = '0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    step(1, 32'h0050_0093, 64'h8000_0000, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    cmp("reset_zero", dut_view(), '0);

    step(1, 32'h0050_0093, 64'h8000_0000, 64'd0, 64'h1234, 1, 0, 0);
    step(1, 32'h0080_00EF, 64'h8000_0010, 64'd7, 64'd9, 1, 0, 0);
    step(1, 32'hFFFF_F0B7, 64'h8000_0014, 64'd7, 64'd9, 1, 0, 0);
    step(1, 32'h1234_5297, 64'h8000_0018, 64'd7, 64'd9, 1, 0, 0);
    step(1, 32'h0081_00E7, 64'h8000_001C, 64'h8000_2000, 64'd9, 1, 0, 0);
    step(1, 32'hFE51_3C23, 64'h8000_0020, 64'h8000_3000, 64'hDEAD_BEEF_0BAD_F00D, 1, 0, 0);
    step(1, 32'h0010_0073, 64'h8000_0024, 64'd1, 64'd2, 1, 0, 0);

    // backpressure: one capture, three blocked cycles, then streaming
    for (int i = 0; i < 4; i++)
      step(1, 32'h0011_0113 + 32'(i << 20), 64'h8000_0100 + 64'(4 * i), 64'(i), 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step(1, 32'h0021_0193 + 32'(i << 20), 64'h8000_0200 + 64'(4 * i), 64'(i), 0, 1, 0, 0);

    // flush with a held output and a fresh instruction offered
    step(1, 32'h0000_0000, 64'h8000_0300, 0, 0, 0, 0, 0);
    step(1, 32'h0000_0000, 64'h8000_0304, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);

    // invalid instructions: three, then two more to saturate the narrow counter
    for (int i = 0; i < 5; i++)
      step(1, 32'h0000_0000, 64'h8000_0400 + 64'(4 * i), 0, 0, 1, 0, 0);

    // reset while a stalled output is held
    step(1, 32'h0050_0093, 64'h8000_0500, 64'd3, 0, 0, 0, 0);
    step(1, 32'h0050_0093, 64'h8000_0504, 64'd3, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    cmp("midreset_zero", dut_view(), '0);

    for (int i = 0; i < 400; i++) begin
      pc = {32'h0, $urandom} & 64'hFFFF_FFFC;
      step(($urandom_range(0, 3) != 0), rand_inst(), {32'($urandom), pc[31:0]},
           {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), 1'b0);
    end

    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 0, 0);
    cmp_v("drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_22040237_idu_stage.md
YSYX_22040237_IDU_STAGE -- requirements
Module: ysyx_22040237_idu_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width (32 or 64).
REQ-002 SHALL have parameter CNTW, default 16, invalid-instruction counter width.
REQ-003 SHALL have port clk  input  1  sole clock, all state rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1  upstream handshake.
REQ-006 SHALL have ports in_pc input XLEN, in_inst input 32  fetched pc/instruction.
REQ-007 SHALL have ports rs1_r_en, rs2_r_en output 1 and rs1_r_addr, rs2_r_addr output 5  register-file read request, combinational from in_inst.
REQ-008 SHALL have ports rs1_data, rs2_data input XLEN  register-file read data, same cycle.
REQ-009 SHALL have port flush input 1  discard held and incoming instruction.
REQ-010 SHALL have ports out_valid output 1, out_ready input 1  downstream handshake.
REQ-011 SHALL have registered outputs out_pc XLEN, out_opcode 8, op1, op2, op1_jump, op2_jump, store_data XLEN, jump_flag 1, is_store 1, inst_ebreak 1, invalid_inst 1, rd_w_en 1, rd_w_addr 5.
REQ-012 SHALL have port invalid_cnt output CNTW  count of accepted invalid instructions.

Function
REQ-013 SHALL decode addi, ebreak, auipc, lui, jal, jalr, sd; any other encoding is invalid.
REQ-014 SHALL sign-extend I, S, U, J immediates to XLEN (U = inst[31:12]<<12, J bit 0 = 0).
REQ-015 SHALL compute: addi op1=rs1_data op2=imm_i; lui op1=0 op2=imm_u; auipc op1=pc op2=imm_u; jal op1=pc op2=4 op1_jump=pc op2_jump=imm_j; jalr op1=pc op2=4 op1_jump=rs1_data op2_jump=imm_i; sd op1=rs1_data op2=imm_s store_data=rs2_data; unused operands 0.
REQ-016 SHALL assert rs1_r_en only for in_valid with addi/jalr/sd, rs2_r_en only for in_valid with sd; addresses 0 when enable low.
REQ-017 SHALL set rd_w_en=1 with rd_w_addr=inst[11:7] for addi/auipc/lui/jal/jalr, else rd_w_en=0, rd_w_addr=0.
REQ-018 SHALL set out_opcode=8'h01 for addi/auipc/lui/jal/jalr, 8'h02 for sd, 8'h00 otherwise; jump_flag=jal|jalr.
REQ-019 SHALL drive in_ready = ~flush & (~out_valid | out_ready).
REQ-020 SHALL capture decoded fields into output registers on in_valid & in_ready, with latency one cycle, and set out_valid=1.
REQ-021 SHALL clear out_valid on out_valid & out_ready without capture in the same cycle.
REQ-022 SHALL hold all output registers stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, on flush, clear out_valid next cycle and accept nothing that cycle; flush overrides capture and out_ready.
REQ-024 SHALL increment invalid_cnt by 1 on each accepted invalid instruction, saturating at all-ones; flushed instructions not counted.
REQ-025 SHALL zero op/jump/store/flag outputs for invalid instructions while still raising out_valid and invalid_inst.

Reset
REQ-026 SHALL, with rst high at a clock edge, set out_valid=0, invalid_cnt=0 and all registered outputs to 0, regardless of in_valid/flush.
REQ-027 SHALL force in_ready=0 while rst is high; a held instruction is lost on mid-operation reset.

Verification
REQ-028 SHALL verify addi: in_inst=0x00500093, pc=0x80000000, rs1_data=0 -> next cycle out_valid=1, op1=0, op2=5, rd_w_en=1, rd_w_addr=1, out_opcode=0x01.
REQ-029 SHALL verify jal: in_inst=0x008000EF, pc=0x80000010 -> op1=0x80000010, op2=4, op1_jump=0x80000010, op2_jump=8, jump_flag=1; lui 0xFFFFF0B7 at XLEN=64 -> op2=0xFFFFFFFFFFFFF000.
REQ-030 SHALL verify backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged, then out_ready=1 -> one transfer per cycle, no loss or duplication.
REQ-031 SHALL verify flush: flush=1 with out_valid=1 and in_valid=1 -> next cycle out_valid=0, invalid_cnt unchanged.
REQ-032 SHALL verify invalid: three accepted 0x00000000 instructions -> invalid_inst=1 each, invalid_cnt=3; CNTW=2 with five -> invalid_cnt=3 (saturated).
REQ-033 SHALL verify reset mid-stream: rst=1 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, all outputs 0, invalid_cnt=0.
